// File: rtl/seg7_capture_decoder.sv
// Recovers BCD digits from a time-multiplexed 7-segment bus and assembles one packed word per scan.
// Define SEG7_ALT_GLYPH_EN to also accept the alternate 6/7/9 glyphs (1F, 72, 73).
module seg7_capture_decoder #(
  parameter int NDIG   = 2,
  parameter int SETTLE = 3,
  localparam int IDX_W = (NDIG > 1) ? $clog2(NDIG) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [6:0]        seg,
  input  logic [NDIG-1:0]   dig_en,
  output logic              digit_valid,
  output logic [IDX_W-1:0]  digit_idx,
  output logic [3:0]        digit_bcd,
  output logic [4*NDIG-1:0] bcd_out,
  output logic              frame_valid,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(SETTLE + 1);

  typedef enum logic [1:0] {BLANK, SETTLING, SAMPLED} state_t;

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic [6:0]        seg_p0;
  logic [NDIG-1:0]   dig_p0;
  logic [4*NDIG-1:0] stage, stage_nxt;
  logic [NDIG-1:0]   mask, mask_nxt;
  logic              bad;
  logic              changed, onehot, multi, take, commit, has_bad_glyph;
  logic [IDX_W-1:0]  idx;
  logic [3:0]        bcd;

  function automatic logic [3:0] decode(input logic [6:0] s);
    case (s)
      7'h7E:   decode = 4'd0;
      7'h30:   decode = 4'd1;
      7'h6D:   decode = 4'd2;
      7'h79:   decode = 4'd3;
      7'h33:   decode = 4'd4;
      7'h5B:   decode = 4'd5;
      7'h5F:   decode = 4'd6;
      7'h70:   decode = 4'd7;
      7'h7F:   decode = 4'd8;
      7'h7B:   decode = 4'd9;
`ifdef SEG7_ALT_GLYPH_EN
      7'h1F:   decode = 4'd6;
      7'h72:   decode = 4'd7;
      7'h73:   decode = 4'd9;
`endif
      default: decode = 4'hF;
    endcase
  endfunction

  always_comb begin
    changed = (seg != seg_p0) || (dig_en != dig_p0);
    onehot  = (dig_en != '0) && ((dig_en & (dig_en - NDIG'(1))) == '0);
    multi   = (dig_en != '0) && !onehot;

    state_nxt = state;
    cnt_nxt   = cnt;
    take      = 1'b0;
    if (!onehot) begin
      state_nxt = BLANK;
      cnt_nxt   = '0;
    end else if (changed || state != SAMPLED) begin
      // The cycle a new value first appears counts as its first stable cycle.
      cnt_nxt = (changed || state == BLANK) ? '0 : cnt + CNT_W'(1);
      if (cnt_nxt == CNT_W'(SETTLE - 1)) begin
        take      = 1'b1;
        state_nxt = SAMPLED;
      end else begin
        state_nxt = SETTLING;
      end
    end

    idx = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (dig_en[i]) idx = IDX_W'(i);
    end
    bcd = decode(seg);

    stage_nxt = stage;
    stage_nxt[idx*4 +: 4] = bcd;
    mask_nxt = mask | (NDIG'(1) << idx);
    commit   = take && (mask_nxt == '1);

    has_bad_glyph = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (stage_nxt[k*4 +: 4] == 4'hF) has_bad_glyph = 1'b1;
    end
  end

  // Stage boundary: input history, strobe tracking and frame assembly registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= BLANK;
      cnt         <= '0;
      seg_p0      <= '0;
      dig_p0      <= '0;
      stage       <= '0;
      mask        <= '0;
      bad         <= 1'b0;
      digit_valid <= 1'b0;
      digit_idx   <= '0;
      digit_bcd   <= '0;
      bcd_out     <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      seg_p0      <= seg;
      dig_p0      <= dig_en;
      digit_valid <= take;
      frame_valid <= commit;
      frame_err   <= commit && (has_bad_glyph || bad);
      // A bad enable seen on the commit edge belongs to the following frame.
      bad         <= commit ? multi : (bad || multi);
      if (take) begin
        digit_idx <= idx;
        digit_bcd <= bcd;
        stage     <= stage_nxt;
        mask      <= commit ? '0 : mask_nxt;
        if (commit) bcd_out <= stage_nxt;
      end
    end
  end

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder (NDIG=2, SETTLE=3) with hand-computed expectations.
module tb_seg7_capture_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [6:0] seg = '0;
  logic [1:0] dig_en = '0;
  logic       digit_valid;
  logic [0:0] digit_idx;
  logic [3:0] digit_bcd;
  logic [7:0] bcd_out;
  logic       frame_valid;
  logic       frame_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  int         dv_n = 0;
  int         dv_cyc = 0;
  logic [3:0] dv_bcd = '0;
  logic       dv_idx = 1'b0;
  int         fv_n = 0;
  int         fv_cyc = 0;
  logic [7:0] fv_bcd = '0;
  logic       fv_err = 1'b0;

  int start, n0, f0;

  seg7_capture_decoder #(.NDIG(2), .SETTLE(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .dig_en      (dig_en),
    .digit_valid (digit_valid),
    .digit_idx   (digit_idx),
    .digit_bcd   (digit_bcd),
    .bcd_out     (bcd_out),
    .frame_valid (frame_valid),
    .frame_err   (frame_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (digit_valid) begin
      dv_n   <= dv_n + 1;
      dv_cyc <= cyc;
      dv_bcd <= digit_bcd;
      dv_idx <= digit_idx[0];
    end
    if (frame_valid) begin
      fv_n   <= fv_n + 1;
      fv_cyc <= cyc;
      fv_bcd <= bcd_out;
      fv_err <= frame_err;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a rising edge; applies the inputs for n clock cycles.
  task automatic hold(input logic [6:0] s, input logic [1:0] d, input int n);
    seg    = s;
    dig_en = d;
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Idle after reset.
    hold(7'h00, 2'b00, 10);
    check("idle_dv_count", dv_n, 0);
    check("idle_fv_count", fv_n, 0);
    check("idle_bcd_out", bcd_out, 8'h00);
    check("idle_digit_bcd", digit_bcd, 4'h0);
    check("idle_frame_err", frame_err, 1'b0);

    // Basic frame: 1 then 9.
    start = cyc;
    hold(7'h30, 2'b01, 4);
    check("t2_dv0_cycle", dv_cyc - start, 3);
    check("t2_dv0_bcd", dv_bcd, 4'd1);
    check("t2_dv0_idx", dv_idx, 1'b0);
    check("t2_no_frame_yet", fv_n, 0);
    hold(7'h7B, 2'b10, 4);
    check("t2_dv1_cycle", dv_cyc - start, 7);
    check("t2_dv1_bcd", dv_bcd, 4'd9);
    check("t2_dv1_idx", dv_idx, 1'b1);
    check("t2_fv_count", fv_n, 1);
    check("t2_fv_cycle", fv_cyc - start, 7);
    check("t2_bcd_out", fv_bcd, 8'h91);
    check("t2_frame_err", fv_err, 1'b0);

    // Short strobe, then a glitch that delays the sample.
    n0 = dv_n;
    hold(7'h30, 2'b01, 2);
    hold(7'h00, 2'b00, 3);
    check("t3_short_no_dv", dv_n, n0);
    check("t3_bcd_out_holds", bcd_out, 8'h91);
    start = cyc;
    hold(7'h6D, 2'b01, 2);
    hold(7'h79, 2'b01, 4);
    check("t3_glitch_dv_count", dv_n, n0 + 1);
    check("t3_glitch_bcd", dv_bcd, 4'd3);
    check("t3_glitch_cycle", dv_cyc - start, 5);
    hold(7'h5B, 2'b10, 4);
    check("t3_fv_count", fv_n, 2);
    check("t3_bcd_out", fv_bcd, 8'h53);
    check("t3_frame_err", fv_err, 1'b0);

    // Alternate glyph for 6.
    hold(7'h1F, 2'b01, 4);
`ifdef SEG7_ALT_GLYPH_EN
    check("t4_digit_bcd", dv_bcd, 4'd6);
`else
    check("t4_digit_bcd", dv_bcd, 4'hF);
`endif
    hold(7'h6D, 2'b10, 4);
    check("t4_fv_count", fv_n, 3);
`ifdef SEG7_ALT_GLYPH_EN
    check("t4_bcd_out", fv_bcd, 8'h26);
    check("t4_frame_err", fv_err, 1'b0);
`else
    check("t4_bcd_out", fv_bcd, 8'h2F);
    check("t4_frame_err", fv_err, 1'b1);
`endif

    // Bad enable mid-frame, resample of digit 0, then a clean frame.
    hold(7'h7E, 2'b01, 4);
    n0 = dv_n;
    hold(7'h7E, 2'b11, 5);
    check("t5_multi_no_dv", dv_n, n0);
    hold(7'h30, 2'b01, 4);
    check("t5_no_frame_on_resample", fv_n, 3);
    hold(7'h6D, 2'b10, 4);
    check("t5_fv_count", fv_n, 4);
    check("t5_bcd_out", fv_bcd, 8'h21);
    check("t5_frame_err", fv_err, 1'b1);
    hold(7'h5F, 2'b01, 4);
    hold(7'h70, 2'b10, 4);
    check("t5_clean_fv_count", fv_n, 5);
    check("t5_clean_bcd_out", fv_bcd, 8'h76);
    check("t5_clean_frame_err", fv_err, 1'b0);

    // Reset after digit 0 was sampled.
    f0 = fv_n;
    hold(7'h7F, 2'b01, 4);
    check("t6_dv_bcd", dv_bcd, 4'd8);
    rst = 1'b1;
    hold(7'h00, 2'b00, 2);
    check("t6_rst_bcd_out", bcd_out, 8'h00);
    check("t6_rst_digit_valid", digit_valid, 1'b0);
    rst = 1'b0;
    hold(7'h00, 2'b00, 2);
    hold(7'h7F, 2'b10, 4);
    check("t6_partial_discarded", fv_n, f0);
    check("t6_bcd_out_still_zero", bcd_out, 8'h00);
    hold(7'h33, 2'b01, 4);
    check("t6_fv_count", fv_n, f0 + 1);
    check("t6_bcd_out", fv_bcd, 8'h84);
    check("t6_frame_err", fv_err, 1'b0);

    hold(7'h00, 2'b00, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
